// File: rtl/ddr_line_arbiter_pkg.sv
// Shared constants and types for the Next186 SDRAM line path
// (arbiter and cache controller).
package next186_ddr_pkg;

  localparam int ADDR  = 25;
  localparam int LINE  = 6;
  localparam int BEATS = 2 ** (LINE - 1);

  localparam int REQ_VGA   = 0;
  localparam int REQ_CACHE = 1;
  localparam int REQ_DMA   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  function automatic logic [15:0] mux16_onehot(input logic [2:0] sel, input logic [47:0] data);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      r = r | ({16{sel[i]}} & data[i*16 +: 16]);
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr_line_arbiter_if.sv
// Requester and SDRAM-side signals of the line arbiter; the arbiter takes the
// master view, requesters/SDRAM controller the slave view.
interface ddr_line_arbiter_if
  import next186_ddr_pkg::*;
#(
  parameter int ADDR = next186_ddr_pkg::ADDR,
  parameter int LINE = next186_ddr_pkg::LINE
);

  localparam int LA = ADDR - LINE;

  logic [2:0]      req_rd;
  logic [2:0]      req_wr;
  logic [3*LA-1:0] req_addr;
  logic [47:0]     req_wdata;
  logic [2:0]      gnt;
  logic [2:0]      rd_stb;
  logic [2:0]      wr_stb;
  logic            mem_cmd_valid;
  logic            mem_cmd_we;
  logic [LA-1:0]   mem_cmd_addr;
  logic            mem_cmd_ready;
  logic            mem_rd_valid;
  logic            mem_wr_req;
  logic [15:0]     mem_wdata;

  modport master (
    input  req_rd, req_wr, req_addr, req_wdata,
    input  mem_cmd_ready, mem_rd_valid, mem_wr_req,
    output gnt, rd_stb, wr_stb,
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata
  );

  modport slave (
    output req_rd, req_wr, req_addr, req_wdata,
    output mem_cmd_ready, mem_rd_valid, mem_wr_req,
    input  gnt, rd_stb, wr_stb,
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata
  );

endinterface

// File: rtl/ddr_line_arbiter_pick.sv
// Winner selection: VGA has fixed top priority, cache and DMA alternate
// according to the round-robin pointer (rr_dma = 1 favours DMA).
module ddr_arb_pick
  import next186_ddr_pkg::*;
(
  input  logic [2:0] pending,
  input  logic       rr_dma,
  output logic [2:0] win,
  output logic       any
);

  // One-hot winner from the pending bits and the round-robin pointer.
  always_comb begin
    win = 3'b000;
    if (pending[REQ_VGA]) begin
      win[REQ_VGA] = 1'b1;
    end else if (pending[REQ_CACHE] && (!rr_dma || !pending[REQ_DMA])) begin
      win[REQ_CACHE] = 1'b1;
    end else if (pending[REQ_DMA]) begin
      win[REQ_DMA] = 1'b1;
    end else begin
      win = 3'b000;
    end
  end

  assign any = |pending;

endmodule

// File: rtl/ddr_line_arbiter.sv
// Shares the SDRAM line-burst port between VGA, cache and DMA requesters.
// DDR_LINE_ARB_WDOG_EN adds the WDOG parameter, a stall watchdog and the wdog_err port.
module ddr_line_arbiter
  import next186_ddr_pkg::*;
#(
  parameter int ADDR = next186_ddr_pkg::ADDR,
  parameter int LINE = next186_ddr_pkg::LINE
`ifdef DDR_LINE_ARB_WDOG_EN
  ,
  parameter int WDOG = 255
`endif
) (
  input  logic ddr_clk,
  input  logic rst_n,
  ddr_line_arbiter_if.master bus
`ifdef DDR_LINE_ARB_WDOG_EN
  ,
  output logic wdog_err
`endif
);

  localparam int LA = ADDR - LINE;
  localparam int BW = LINE - 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_CMD  = 2'(CMD);
  localparam logic [1:0] S_XFER = 2'(XFER);
  localparam logic [1:0] S_DONE = 2'(DONE);

  localparam logic [BW-1:0] BEAT_LAST = {BW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_we_q, cmd_we_d;
  logic [LA-1:0] cmd_addr_q, cmd_addr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          rr_q, rr_d;

  logic [2:0]    pending;
  logic [2:0]    win;
  logic          win_any;
  logic [LA-1:0] win_addr;
  logic          in_xfer;
  logic          cmd_accept;
  logic          beat;
  logic          wdog_trip;

  assign pending = bus.req_rd | bus.req_wr;

  ddr_arb_pick u_pick (
    .pending (pending),
    .rr_dma  (rr_q),
    .win     (win),
    .any     (win_any)
  );

  // Line address of the arbitration winner (zero when nobody wins).
  always_comb begin
    win_addr = {LA{1'b0}};
    for (int i = 0; i < 3; i++) begin
      win_addr = win_addr | ({LA{win[i]}} & bus.req_addr[i*LA +: LA]);
    end
  end

  assign in_xfer    = (state_q == S_XFER);
  assign cmd_accept = (state_q == S_CMD) & bus.mem_cmd_ready;
  assign beat       = in_xfer & (cmd_we_q ? bus.mem_wr_req : bus.mem_rd_valid);

  // Strobes only pass through in XFER and only for the burst direction in flight.
  assign bus.rd_stb    = (in_xfer & ~cmd_we_q) ? (gnt_q & {3{bus.mem_rd_valid}}) : 3'b000;
  assign bus.wr_stb    = (in_xfer &  cmd_we_q) ? (gnt_q & {3{bus.mem_wr_req}})   : 3'b000;
  assign bus.mem_wdata = mux16_onehot(gnt_q, bus.req_wdata);

  assign bus.gnt           = gnt_q;
  assign bus.mem_cmd_valid = cmd_valid_q;
  assign bus.mem_cmd_we    = cmd_we_q;
  assign bus.mem_cmd_addr  = cmd_addr_q;

  // Burst sequencing: arbitrate, hold command, count beats, one-cycle gap.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    beat_d      = beat_q;
    rr_d        = rr_q;
    case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d     = S_CMD;
          gnt_d       = win;
          cmd_valid_d = 1'b1;
          cmd_we_d    = |(win & bus.req_wr);
          cmd_addr_d  = win_addr;
          rr_d        = win[REQ_CACHE] ? 1'b1 : (win[REQ_DMA] ? 1'b0 : rr_q);
        end else begin
          state_d = S_IDLE;
          gnt_d   = 3'b000;
        end
      end
      S_CMD: begin
        if (bus.mem_cmd_ready) begin
          cmd_valid_d = 1'b0;
          beat_d      = {BW{1'b0}};
          state_d     = S_XFER;
        end else if (wdog_trip) begin
          cmd_valid_d = 1'b0;
          gnt_d       = 3'b000;
          state_d     = S_DONE;
        end else begin
          state_d = S_CMD;
        end
      end
      S_XFER: begin
        if (beat) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = {BW{1'b0}};
            gnt_d   = 3'b000;
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + {{(BW-1){1'b0}}, 1'b1};
          end
        end else if (wdog_trip) begin
          beat_d  = {BW{1'b0}};
          gnt_d   = 3'b000;
          state_d = S_DONE;
        end else begin
          state_d = S_XFER;
        end
      end
      S_DONE: begin
        gnt_d   = 3'b000;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d       = 3'b000;
        cmd_valid_d = 1'b0;
        beat_d      = {BW{1'b0}};
        state_d     = S_IDLE;
      end
    endcase
  end

  // Arbiter state and the registered command/grant outputs.
  always_ff @(posedge ddr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 3'b000;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= {LA{1'b0}};
      beat_q      <= {BW{1'b0}};
      rr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      beat_q      <= beat_d;
      rr_q        <= rr_d;
    end
  end

`ifdef DDR_LINE_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG + 1);

  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_err_q, wdog_err_d;
  logic          busy;

  assign busy = (state_q == S_CMD) | (state_q == S_XFER);

  // Stall counter: restarts outside a burst, on command accept and on each beat.
  always_comb begin
    wdog_cnt_d = {WW{1'b0}};
    wdog_err_d = wdog_err_q;
    wdog_trip  = 1'b0;
    if (!busy || beat || cmd_accept) begin
      wdog_cnt_d = {WW{1'b0}};
    end else if (wdog_cnt_q == WW'(WDOG - 1)) begin
      wdog_trip  = 1'b1;
      wdog_err_d = 1'b1;
    end else begin
      wdog_cnt_d = wdog_cnt_q + {{(WW-1){1'b0}}, 1'b1};
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge ddr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= {WW{1'b0}};
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_line_arbiter.sv
// Directed self-checking bench for ddr_line_arbiter; the watchdog case is
// exercised when DDR_LINE_ARB_WDOG_EN is defined.
module tb_ddr_line_arbiter;
  import next186_ddr_pkg::*;

  localparam int LA = ADDR - LINE;

  logic ddr_clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  ddr_line_arbiter_if #(.ADDR(ADDR), .LINE(LINE)) bus ();

`ifdef DDR_LINE_ARB_WDOG_EN
  logic wdog_err;
`endif

  ddr_line_arbiter #(.ADDR(ADDR), .LINE(LINE)) dut (
    .ddr_clk (ddr_clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef DDR_LINE_ARB_WDOG_EN
    ,
    .wdog_err(wdog_err)
`endif
  );

  always #5 ddr_clk = ~ddr_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic rd, input logic wr, input logic [LA-1:0] addr);
    bus.req_rd[idx] = rd;
    bus.req_wr[idx] = wr;
    bus.req_addr[idx*LA +: LA] = addr;
  endtask

  // Waits for a command, checks it, optionally stalls ready, then runs nbeats beats.
  task automatic burst(input int idx, input logic we, input logic [LA-1:0] addr,
                       input int stall, input int nbeats, input bit gap);
    bit ok;
    logic [15:0] w;
    logic [2:0] exp_g;
    ok = 1'b0;
    exp_g = 3'(1 << idx);
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_cmd_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check_eq("cmd_seen", 32'(ok), 32'd1);
    check_eq("cmd_gnt", 32'(bus.gnt), 32'(exp_g));
    check_eq("cmd_addr", 32'(bus.mem_cmd_addr), 32'(addr));
    check_eq("cmd_we", 32'(bus.mem_cmd_we), 32'(we));
    bus.req_rd[idx] = 1'b0;
    bus.req_wr[idx] = 1'b0;
    for (int s = 0; s < stall; s++) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_wr_req   = 1'b1;
      #1;
      check_eq("stall_valid", 32'(bus.mem_cmd_valid), 32'd1);
      check_eq("stall_addr", 32'(bus.mem_cmd_addr), 32'(addr));
      check_eq("stall_we", 32'(bus.mem_cmd_we), 32'(we));
      check_eq("stall_stb", 32'({bus.rd_stb, bus.wr_stb}), 32'd0);
      step();
    end
    bus.mem_rd_valid  = 1'b0;
    bus.mem_wr_req    = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    step();
    bus.mem_cmd_ready = 1'b0;
    check_eq("accept_valid", 32'(bus.mem_cmd_valid), 32'd0);
    for (int b = 0; b < nbeats; b++) begin
      if (gap && (b % 2 == 1)) step();
      w = 16'hA000 + 16'(b) + 16'(idx << 8);
      if (we) begin
        bus.req_wdata[idx*16 +: 16] = w;
        bus.mem_wr_req = 1'b1;
      end else begin
        bus.mem_rd_valid = 1'b1;
      end
      #1;
      check_eq(we ? "beat_wr_stb" : "beat_rd_stb", 32'(we ? bus.wr_stb : bus.rd_stb), 32'(exp_g));
      check_eq("beat_other_stb", 32'(we ? bus.rd_stb : bus.wr_stb), 32'd0);
      if (we) check_eq("beat_wdata", 32'(bus.mem_wdata), 32'(w));
      step();
      bus.mem_rd_valid = 1'b0;
      bus.mem_wr_req   = 1'b0;
    end
    if (nbeats == BEATS) begin
      check_eq("done_gnt", 32'(bus.gnt), 32'd0);
      bus.mem_rd_valid = 1'b1;
      bus.mem_wr_req   = 1'b1;
      #1;
      check_eq("done_stb", 32'({bus.rd_stb, bus.wr_stb}), 32'd0);
      bus.mem_rd_valid = 1'b0;
      bus.mem_wr_req   = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    rst_n             = 1'b0;
    bus.req_rd        = 3'b000;
    bus.req_wr        = 3'b000;
    bus.req_addr      = {(3*LA){1'b0}};
    bus.req_wdata     = 48'h3333_2222_1111;
    bus.mem_cmd_ready = 1'b0;
    bus.mem_rd_valid  = 1'b0;
    bus.mem_wr_req    = 1'b0;
    #3;
    check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("rst_valid", 32'(bus.mem_cmd_valid), 32'd0);
    check_eq("rst_we", 32'(bus.mem_cmd_we), 32'd0);
    check_eq("rst_addr", 32'(bus.mem_cmd_addr), 32'd0);
    check_eq("rst_stb", 32'({bus.rd_stb, bus.wr_stb}), 32'd0);
`ifdef DDR_LINE_ARB_WDOG_EN
    check_eq("rst_wdog", 32'(wdog_err), 32'd0);
`endif
    #20 rst_n = 1'b1;
    step();

    // All three request: VGA first, then cache (pointer at reset), VGA again by priority, then DMA.
    set_req(0, 1'b1, 1'b0, 19'h00100);
    set_req(1, 1'b1, 1'b0, 19'h00101);
    set_req(2, 1'b1, 1'b0, 19'h00102);
    burst(0, 1'b0, 19'h00100, 0, BEATS, 1'b0);
    burst(1, 1'b0, 19'h00101, 0, BEATS, 1'b0);
    set_req(0, 1'b1, 1'b0, 19'h00103);
    burst(0, 1'b0, 19'h00103, 0, BEATS, 1'b0);
    burst(2, 1'b0, 19'h00102, 0, BEATS, 1'b0);

    // Cache-only read at 0x1A3 with exact one-cycle decision latency and gapped beats.
    step();
    check_eq("idle_gnt", 32'(bus.gnt), 32'd0);
    set_req(1, 1'b1, 1'b0, 19'h001A3);
    step();
    check_eq("lat_valid", 32'(bus.mem_cmd_valid), 32'd1);
    burst(1, 1'b0, 19'h001A3, 0, BEATS, 1'b1);

    // Pointer now favours DMA: DMA before cache.
    set_req(1, 1'b1, 1'b0, 19'h00011);
    set_req(2, 1'b1, 1'b0, 19'h00022);
    burst(2, 1'b0, 19'h00022, 0, BEATS, 1'b0);
    burst(1, 1'b0, 19'h00011, 0, BEATS, 1'b0);

    // Cache writeback then fill requested during the DONE gap.
    set_req(1, 1'b0, 1'b1, 19'h00055);
    burst(1, 1'b1, 19'h00055, 0, BEATS, 1'b0);
    set_req(1, 1'b1, 1'b0, 19'h000AA);
    burst(1, 1'b0, 19'h000AA, 0, BEATS, 1'b0);

    // DMA write with mem_cmd_ready held low for 10 cycles.
    set_req(2, 1'b0, 1'b1, 19'h003C5);
    burst(2, 1'b1, 19'h003C5, 10, BEATS, 1'b0);

    // Reset after beat 17 of a read, then a fresh full burst.
    set_req(1, 1'b1, 1'b0, 19'h002F0);
    burst(1, 1'b0, 19'h002F0, 0, 17, 1'b0);
    bus.mem_rd_valid = 1'b1;
    #1;
    check_eq("pre_rst_stb", 32'(bus.rd_stb), 32'h2);
    rst_n = 1'b0;
    #1;
    check_eq("async_gnt", 32'(bus.gnt), 32'd0);
    check_eq("async_stb", 32'(bus.rd_stb), 32'd0);
    check_eq("async_valid", 32'(bus.mem_cmd_valid), 32'd0);
    bus.mem_rd_valid = 1'b0;
    #3 rst_n = 1'b1;
    step();
    set_req(0, 1'b1, 1'b0, 19'h0007E);
    burst(0, 1'b0, 19'h0007E, 0, BEATS, 1'b0);

`ifdef DDR_LINE_ARB_WDOG_EN
    begin
      int cyc;
      step();
      set_req(1, 1'b1, 1'b0, 19'h00123);
      burst(1, 1'b0, 19'h00123, 0, 5, 1'b0);
      cyc = 0;
      while (!wdog_err && cyc < 400) begin
        step();
        cyc++;
      end
      check_eq("wdog_cycles", 32'(cyc), 32'd255);
      check_eq("wdog_gnt", 32'(bus.gnt), 32'd0);
      step();
      set_req(0, 1'b1, 1'b0, 19'h00001);
      burst(0, 1'b0, 19'h00001, 0, BEATS, 1'b0);
      check_eq("wdog_sticky", 32'(wdog_err), 32'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
